// File: rtl/blinking_machine_pkg.sv
// Shared types and defaults for the blinking machine.
// Optional feature macro: BLINK_REPEAT_EN (see blinking_machine.sv).
package blinking_machine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned CLK_FREQ_DEF   = 50_000_000;
  localparam int unsigned BLINK_FREQ_DEF = 1;
  localparam int unsigned NUM_BLINKS_DEF = 3;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/blinking_machine_clk_divider.sv
// Free-running divider: counts 0..HALF-1, pulses tick on HALF-1 and
// toggles clk_out on that same edge, giving a 2*HALF-cycle square wave.
module clk_divider
  import blinking_machine_pkg::*;
#(
  parameter int unsigned HALF = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic clk_out
);

  localparam int unsigned  CW   = width_of(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // Half-period counter, wraps after the terminal value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    count <= '0;
    else if (tick) count <= '0;
    else           count <= count + CW'(1);
  end

  // Divided clock toggles once per half period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    clk_out <= 1'b0;
    else if (tick) clk_out <= ~clk_out;
  end

endmodule

// File: rtl/blinking_machine.sv
// Blinking machine: emits NUM_BLINKS half-period pulses on out, aligned
// to the divided clock, while start is held.
// Optional feature macro: BLINK_REPEAT_EN -- when defined the sequence
// restarts automatically while start stays high; otherwise it stops in
// DONE until start is released.
//
// state | meaning
// IDLE  | waiting for a tick with start high; blink counter cleared
// ON    | out lit for one half period
// OFF   | out dark for one half period; decides next blink or end
// DONE  | sequence complete, waiting for start to drop
module blinking_machine
  import blinking_machine_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
  parameter int unsigned BLINK_FREQ = BLINK_FREQ_DEF,
  parameter int unsigned NUM_BLINKS = NUM_BLINKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic out,
  output logic clk_1hz
);

  localparam int unsigned   HALF       = CLK_FREQ / (2 * BLINK_FREQ);
  localparam int unsigned   BW         = $clog2(NUM_BLINKS + 1);
  localparam logic [BW-1:0] LAST_BLINK = BW'(NUM_BLINKS);

  state_t        state;
  state_t        next_state;
  logic [BW-1:0] blink_cnt;
  logic          tick;
  logic          out_d;
  logic          blink_clr;
  logic          blink_inc;

  clk_divider #(.HALF(HALF)) u_div (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .clk_out (clk_1hz)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: dropping start aborts immediately; everything else waits for tick.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (tick && start) next_state = ON;
      ON: begin
        if (!start)    next_state = IDLE;
        else if (tick) next_state = OFF;
      end
      OFF: begin
        if (!start) next_state = IDLE;
        else if (tick) begin
          if (blink_cnt < LAST_BLINK) next_state = ON;
`ifdef BLINK_REPEAT_EN
          else                        next_state = IDLE;
`else
          else                        next_state = DONE;
`endif
        end
      end
      DONE: if (!start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state so out is a plain flop.
  always_comb begin
    out_d     = (next_state == ON);
    blink_clr = (next_state == IDLE);
    blink_inc = (state == ON) && (next_state == OFF);
  end

  // Blink counter and registered lamp output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      out       <= 1'b0;
    end else begin
      out <= out_d;
      if (blink_clr)      blink_cnt <= '0;
      else if (blink_inc) blink_cnt <= blink_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_blinking_machine.sv
// Randomized scoreboard bench for blinking_machine (CLK_FREQ=8, HALF=4,
// NUM_BLINKS=3). Honours BLINK_REPEAT_EN when compiled with it.
module tb_blinking_machine;

  localparam int HALF = 4;
  localparam int NB   = 3;
`ifdef BLINK_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic out;
  logic clk_1hz;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];

  blinking_machine #(
    .CLK_FREQ   (8),
    .BLINK_FREQ (1),
    .NUM_BLINKS (NB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .out     (out),
    .clk_1hz (clk_1hz)
  );

  always #5 clk = ~clk;

  // Reference model: edge index since reset release drives a tick
  // schedule; a sequence started at edge k0 is lit during even
  // half-periods counted from k0 and ends after 2*NB half-periods.
  int k    = 0;
  int k0   = 0;
  int mode = 0;   // 0 waiting, 1 in sequence, 2 finished-hold
  always @(posedge clk) begin
    bit tk;
    bit eo;
    bit ec;
    if (!reset) begin
      k    = 0;
      mode = 0;
      exp_q.push_back(2'b00);
    end else begin
      tk = ((k % HALF) == HALF - 1);
      case (mode)
        0: if (tk && start) begin mode = 1; k0 = k; end
        1: begin
          if (!start) mode = 0;
          else if ((k - k0) == 2 * NB * HALF) mode = REPEAT ? 0 : 2;
        end
        default: if (!start) mode = 0;
      endcase
      eo = (mode == 1) && ((((k - k0) / HALF) % 2) == 0);
      ec = (((k + 1) / HALF) % 2) == 1;
      exp_q.push_back({eo, ec});
      k++;
    end
  end

  // Monitor: compare each cycle's outputs and check out rises with a clk_1hz toggle.
  logic prev_out = 1'b0;
  logic prev_c   = 1'b0;
  always @(negedge clk) begin
    logic [1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({out, clk_1hz} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t out=%b clk_1hz=%b expected out=%b clk_1hz=%b",
                 $time, out, clk_1hz, e[1], e[0]);
      end
      if (out === 1'b1 && prev_out === 1'b0) begin
        checks++;
        if (clk_1hz === prev_c) begin
          errors++;
          $display("FAIL phase_align t=%0t clk_1hz=%b did not toggle (was %b) on out rise",
                   $time, clk_1hz, prev_c);
        end
      end
    end
    prev_out = out;
    prev_c   = clk_1hz;
  end

  task automatic hold(input int n, input logic lvl);
    @(negedge clk);
    start = lvl;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wait_rise(input int max_cycles, input string name);
    logic p;
    bit   found;
    int   i;
    p     = out;
    found = 0;
    i     = 0;
    while (!found && i < max_cycles) begin
      @(negedge clk);
      if (out === 1'b1 && p === 1'b0) found = 1;
      p = out;
      i++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s timeout: out rise not seen within %0d cycles (out=%b)", name, max_cycles, out);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;

    hold(20, 1'b0);
    hold(70, 1'b1);
    hold(3, 1'b0);
    hold(40, 1'b1);
    hold(6, 1'b0);

    // abort two cycles into the second ON window, then a full sequence
    start = 1'b1;
    wait_rise(40, "first_on");
    wait_rise(40, "second_on");
    repeat (2) @(negedge clk);
    start = 1'b0;
    hold(5, 1'b0);
    hold(40, 1'b1);
    hold(3, 1'b0);

    // asynchronous reset in the middle of an ON window
    start = 1'b1;
    wait_rise(40, "pre_reset_on");
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0 || clk_1hz !== 1'b0) begin
      errors++;
      $display("FAIL async_reset out=%b clk_1hz=%b expected 0 0", out, clk_1hz);
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    hold(60, 1'b1);

    for (int s = 0; s < 40; s++)
      hold($urandom_range(1, 40), logic'($urandom_range(0, 1)));
    hold(5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
